// File: rtl/sbox_arb_pkg.sv
// Shared constants and tag record for the S-box BRAM lookup arbiter.
package sbox_arb_pkg;

    localparam int NREQ      = 4;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 8;
    localparam int BRAM_LAT  = 2;
    // Wide enough for any practical requester count; unused upper bits stay zero.
    localparam int TAG_IDX_W = 8;

    typedef struct packed {
        logic                 vld;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-grant round-robin picker: first valid from ptr -> A, second -> B.
module rr_pick2 #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             a_vld,
    output logic [IDX_W-1:0] a_idx,
    output logic             b_vld,
    output logic [IDX_W-1:0] b_idx
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        a_vld = 1'b0;
        a_idx = '0;
        b_vld = 1'b0;
        b_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (valid[idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = IDX_W'(idx);
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = IDX_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/sbox_bram_arbiter.sv
// Shares one dual-port S-box BRAM between NREQ requesters, two lookups per cycle,
// responses three cycles after acceptance.
module sbox_bram_arbiter #(
    parameter int NREQ   = sbox_arb_pkg::NREQ,
    parameter int ADDR_W = sbox_arb_pkg::ADDR_W,
    parameter int DATA_W = sbox_arb_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          resp_valid,
    output logic [NREQ*DATA_W-1:0]   resp_data,
    output logic [ADDR_W-1:0]        bram_addr_a,
    output logic [ADDR_W-1:0]        bram_addr_b,
    output logic                     bram_en,
    output logic                     bram_rst,
    input  logic [DATA_W-1:0]        bram_doa,
    input  logic [DATA_W-1:0]        bram_dob,
    output logic                     busy
);
    import sbox_arb_pkg::*;

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        pick_valid;
    logic                   a_vld;
    logic                   b_vld;
    logic [IDX_W-1:0]       a_idx;
    logic [IDX_W-1:0]       b_idx;

    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    tag_t                   tag_a_q [BRAM_LAT];
    tag_t                   tag_a_d [BRAM_LAT];
    tag_t                   tag_b_q [BRAM_LAT];
    tag_t                   tag_b_d [BRAM_LAT];
    logic [NREQ-1:0]        resp_valid_q, resp_valid_d;
    logic [NREQ*DATA_W-1:0] resp_data_q, resp_data_d;

    // No grants at all while flushing or in reset.
    assign pick_valid = (flush || rst) ? '0 : req_valid;

    rr_pick2 #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (pick_valid),
        .ptr   (rr_ptr_q),
        .a_vld (a_vld),
        .a_idx (a_idx),
        .b_vld (b_vld),
        .b_idx (b_idx)
    );

    always_comb begin
        req_ready = '0;
        if (a_vld) req_ready[a_idx] = 1'b1;
        if (b_vld) req_ready[b_idx] = 1'b1;
        bram_addr_a = a_vld ? req_addr[a_idx*ADDR_W +: ADDR_W] : '0;
        bram_addr_b = b_vld ? req_addr[b_idx*ADDR_W +: ADDR_W] : '0;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (b_vld) begin
            rr_ptr_d = (b_idx == IDX_W'(NREQ-1)) ? '0 : b_idx + 1'b1;
        end else if (a_vld) begin
            rr_ptr_d = (a_idx == IDX_W'(NREQ-1)) ? '0 : a_idx + 1'b1;
        end
    end

    always_comb begin
        tag_a_d[0].vld = a_vld;
        tag_a_d[0].idx = TAG_IDX_W'(a_idx);
        tag_b_d[0].vld = b_vld;
        tag_b_d[0].idx = TAG_IDX_W'(b_idx);
        for (int unsigned s = 1; s < BRAM_LAT; s++) begin
            tag_a_d[s] = tag_a_q[s-1];
            tag_b_d[s] = tag_b_q[s-1];
        end
        if (flush) begin
            for (int unsigned s = 0; s < BRAM_LAT; s++) begin
                tag_a_d[s].vld = 1'b0;
                tag_b_d[s].vld = 1'b0;
            end
        end
    end

    // Last tag stage lines up with the BRAM output register.
    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (!flush) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (tag_a_q[BRAM_LAT-1].vld && tag_a_q[BRAM_LAT-1].idx == TAG_IDX_W'(i)) begin
                    resp_valid_d[i]                  = 1'b1;
                    resp_data_d[i*DATA_W +: DATA_W] = bram_doa;
                end
                if (tag_b_q[BRAM_LAT-1].vld && tag_b_q[BRAM_LAT-1].idx == TAG_IDX_W'(i)) begin
                    resp_valid_d[i]                  = 1'b1;
                    resp_data_d[i*DATA_W +: DATA_W] = bram_dob;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            for (int unsigned s = 0; s < BRAM_LAT; s++) begin
                tag_a_q[s] <= '0;
                tag_b_q[s] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            for (int unsigned s = 0; s < BRAM_LAT; s++) begin
                tag_a_q[s] <= tag_a_d[s];
                tag_b_q[s] <= tag_b_d[s];
            end
        end
    end

    always_comb begin
        logic tags_live;
        tags_live = 1'b0;
        for (int unsigned s = 0; s < BRAM_LAT; s++) begin
            tags_live = tags_live | tag_a_q[s].vld | tag_b_q[s].vld;
        end
        bram_en = a_vld | b_vld | tags_live;
        busy    = tags_live | (|resp_valid_q);
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign bram_rst   = rst;

endmodule

// File: tb/tb_sbox_bram_arbiter.sv
// Directed bench for sbox_bram_arbiter with a behavioural 2-cycle-latency BRAM.
module tb_sbox_bram_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ*DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0]      bram_addr_a;
    logic [ADDR_W-1:0]      bram_addr_b;
    logic                   bram_en;
    logic                   bram_rst;
    logic [DATA_W-1:0]      bram_doa;
    logic [DATA_W-1:0]      bram_dob;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sbox_bram_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .bram_addr_a (bram_addr_a),
        .bram_addr_b (bram_addr_b),
        .bram_en     (bram_en),
        .bram_rst    (bram_rst),
        .bram_doa    (bram_doa),
        .bram_dob    (bram_dob),
        .busy        (busy)
    );

    // Table contents: entry 0 is 0x00, entry 1 is 0x1D.
    function automatic logic [7:0] mem_f(input logic [9:0] a);
        return (a[7:0] * 8'h1D) ^ {a[9:8], 6'b0};
    endfunction

    logic [7:0] lat_a, lat_b;
    always @(posedge clk) begin
        if (bram_rst) begin
            lat_a    <= '0;
            lat_b    <= '0;
            bram_doa <= '0;
            bram_dob <= '0;
        end else if (bram_en) begin
            lat_a    <= mem_f(bram_addr_a);
            lat_b    <= mem_f(bram_addr_b);
            bram_doa <= lat_a;
            bram_dob <= lat_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [9:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [7:0] rd(input int i);
        return resp_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    logic [9:0] a36 [4];
    logic [3:0] exp_rv;

    logic       pending  [4];
    logic [9:0] paddr    [4];
    int         wait_cnt [4];
    logic [3:0] pipe_mask [3];
    logic [9:0] pipe_addr [3][4];
    logic [3:0] acc;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'hF;
        req_addr  = '0;
        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_en", bram_en, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", resp_valid, 0);
        check("rst_rdata", resp_data, 0);
        check("rst_addr_a", bram_addr_a, 0);
        check("rst_bram_rst", bram_rst, 1);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single request, requester 0, address 0.
        set_addr(0, 10'h000);
        req_valid = 4'b0001;
        #1;
        check("s0_ready", req_ready, 4'b0001);
        check("s0_addr_a", bram_addr_a, 10'h000);
        check("s0_addr_b", bram_addr_b, 10'h000);
        check("s0_en", bram_en, 1);
        tick();
        req_valid = '0;
        check("s0_busy", busy, 1);
        check("s0_rv_t1", resp_valid, 0);
        tick();
        check("s0_rv_t2", resp_valid, 0);
        tick();
        check("s0_rv_t3", resp_valid, 4'b0001);
        check("s0_data", rd(0), 8'h00);
        tick();
        check("s0_rv_t4", resp_valid, 0);
        check("s0_busy_end", busy, 0);
        check("s0_en_end", bram_en, 0);

        // Single request from requester 2 with non-zero address (ptr now 1).
        set_addr(2, 10'h2A5);
        req_valid = 4'b0100;
        #1;
        check("s2_ready", req_ready, 4'b0100);
        check("s2_addr_a", bram_addr_a, 10'h2A5);
        check("s2_addr_b", bram_addr_b, 10'h000);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("s2_rv", resp_valid, 4'b0100);
        check("s2_data", rd(2), mem_f(10'h2A5));
        tick();

        // All four requesting from ptr 0: {0,1},{2,3},... then drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a36[i] = 10'h040 + 10'(i * 'h71);
            set_addr(i, a36[i]);
        end
        for (int c = 0; c < 9; c++) begin
            req_valid = (c < 6) ? 4'hF : 4'h0;
            #1;
            check("rr_ready", req_ready, (c < 6) ? ((c % 2 == 0) ? 4'b0011 : 4'b1100) : 4'b0000);
            if (c < 6) begin
                check("rr_addr_a", bram_addr_a, (c % 2 == 0) ? a36[0] : a36[2]);
                check("rr_addr_b", bram_addr_b, (c % 2 == 0) ? a36[1] : a36[3]);
            end
            exp_rv = 4'b0000;
            if (c >= 3) exp_rv = ((c - 3) % 2 == 0) ? 4'b0011 : 4'b1100;
            check("rr_rv", resp_valid, exp_rv);
            for (int i = 0; i < 4; i++) begin
                if (exp_rv[i]) check("rr_data", rd(i), mem_f(a36[i]));
            end
            tick();
        end
        check("rr_busy_end", busy, 0);

        // Requesters 1 and 3 on the same address (ptr back at 0).
        set_addr(1, 10'h001);
        set_addr(3, 10'h001);
        req_valid = 4'b1010;
        #1;
        check("dup_ready", req_ready, 4'b1010);
        check("dup_addr_a", bram_addr_a, 10'h001);
        check("dup_addr_b", bram_addr_b, 10'h001);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("dup_rv", resp_valid, 4'b1010);
        check("dup_data1", rd(1), 8'h1D);
        check("dup_data3", rd(3), 8'h1D);
        tick();

        // Flush one cycle after accepting requester 2.
        set_addr(2, 10'h0F0);
        req_valid = 4'b0100;
        #1;
        check("fl_ready", req_ready, 4'b0100);
        tick();
        flush = 1'b1;
        req_valid = 4'hF;
        #1;
        check("fl_ready_blk", req_ready, 0);
        check("fl_addr_a", bram_addr_a, 0);
        tick();
        flush = 1'b0;
        req_valid = '0;
        #1;
        check("fl_busy", busy, 0);
        check("fl_en", bram_en, 0);
        check("fl_rv_t2", resp_valid, 0);
        tick();
        check("fl_rv_t3", resp_valid, 0);
        tick();
        check("fl_rv_t4", resp_valid, 0);
        check("fl_hold", rd(2), mem_f(10'h122));
        // Pointer must still be 3 after the flush.
        set_addr(0, 10'h155);
        set_addr(3, 10'h3C3);
        req_valid = 4'b1001;
        #1;
        check("fl_ptr_a", bram_addr_a, 10'h3C3);
        check("fl_ptr_b", bram_addr_b, 10'h155);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset one cycle after accepting requester 1 (ptr now 1).
        set_addr(1, 10'h077);
        req_valid = 4'b0010;
        #1;
        check("mr_ready", req_ready, 4'b0010);
        tick();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check("mr_ready_rst", req_ready, 0);
        check("mr_en", bram_en, 0);
        check("mr_busy", busy, 0);
        check("mr_rv", resp_valid, 0);
        check("mr_rdata", resp_data, 0);
        check("mr_addr_a", bram_addr_a, 0);
        check("mr_addr_b", bram_addr_b, 0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        for (int k = 2; k <= 6; k++) begin
            #1;
            check("mr_rv_after", resp_valid, 0);
            check("mr_busy_after", busy, 0);
            tick();
        end

        // Random traffic against a latency-3 expectation pipe.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pending[i]  = 1'b0;
            paddr[i]    = '0;
            wait_cnt[i] = 0;
        end
        for (int s = 0; s < 3; s++) begin
            pipe_mask[s] = '0;
            for (int i = 0; i < 4; i++) pipe_addr[s][i] = '0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            check("rnd_rv", resp_valid, pipe_mask[2]);
            for (int i = 0; i < 4; i++) begin
                if (pipe_mask[2][i]) check("rnd_data", rd(i), mem_f(pipe_addr[2][i]));
            end
            for (int i = 0; i < 4; i++) begin
                if (!pending[i] && cyc < 9990 && $urandom_range(0, 99) < 60) begin
                    pending[i]  = 1'b1;
                    paddr[i]    = 10'($urandom_range(0, 1023));
                    wait_cnt[i] = 0;
                end
                req_valid[i] = pending[i];
                set_addr(i, paddr[i]);
            end
            #1;
            acc = req_ready & req_valid;
            check("rnd_rdy_subset", req_ready & ~req_valid, 0);
            check("rnd_two_max", ($countones(req_ready) <= 2), 1);
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    check("rnd_starve", (wait_cnt[i] <= 2), 1);
                    pending[i] = 1'b0;
                end else if (pending[i]) begin
                    wait_cnt[i]++;
                end
            end
            pipe_mask[2] = pipe_mask[1];
            pipe_mask[1] = pipe_mask[0];
            pipe_mask[0] = acc;
            for (int i = 0; i < 4; i++) begin
                pipe_addr[2][i] = pipe_addr[1][i];
                pipe_addr[1][i] = pipe_addr[0][i];
                pipe_addr[0][i] = paddr[i];
            end
            tick();
        end
        req_valid = '0;
        tick();
        check("rnd_busy_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sbox_bram_arbiter.md
SBOX_BRAM_ARBITER -- requirements
Module: sbox_bram_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of S-box lookup requesters.
REQ-002 Parameter ADDR_W, default 10, BRAM address width: masked byte in bits 7:0, table/mask select in bits 9:8.
REQ-003 Parameter DATA_W, default 8, BRAM read-data width.
REQ-004 Port clk  in  1  single clock, rising-edge.
REQ-005 Port rst  in  1  asynchronous active-high reset.
REQ-006 Port flush  in  1  synchronous drop of all in-flight lookups.
REQ-007 Port req_valid  in  NREQ  per-requester lookup request.
REQ-008 Port req_addr  in  NREQ*ADDR_W  per-requester lookup address, requester i in slice i.
REQ-009 Port req_ready  out  NREQ  per-requester accept; a lookup is accepted when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-010 Port resp_valid  out  NREQ  one-cycle pulse, result for requester i.
REQ-011 Port resp_data  out  NREQ*DATA_W  per-requester result, registered.
REQ-012 Port bram_addr_a / bram_addr_b  out  ADDR_W each  to dual-port S-box BRAM ADDRA/ADDRB.
REQ-013 Port bram_en  out  1  to BRAM EN (port enables and output-register enables).
REQ-014 Port bram_rst  out  1  to BRAM rst, equal to rst.
REQ-015 Port bram_doa / bram_dob  in  DATA_W each  from BRAM DOA/DOB, with the output register enabled (2-edge read latency).
REQ-016 Port busy  out  1  high while any accepted lookup has no response yet.

Function
REQ-017 Each cycle the block SHALL grant at most two requesters, scanning round-robin from pointer rr_ptr: the first valid requester goes to port A, the second to port B.
REQ-018 req_ready[i] SHALL be combinational and high only for granted requesters; it SHALL be 0 for all requesters while flush or rst is high.
REQ-019 bram_addr_a/b SHALL be combinational copies of the granted req_addr; an unused port SHALL drive address 0.
REQ-020 rr_ptr SHALL advance to (last granted index + 1) mod NREQ and wrap NREQ-1 -> 0; rr_ptr SHALL hold when nothing is granted.
REQ-021 A 2-stage tag pipeline SHALL carry {valid, requester index} for each port; stage 2 aligns with bram_doa/bram_dob.
REQ-022 For a lookup accepted in cycle T, resp_valid[i] SHALL pulse in cycle T+3 with resp_data[i] equal to the BRAM content at the accepted address.
REQ-023 resp_data[i] SHALL hold its last value between pulses.
REQ-024 A requester granted on both ports is impossible; within one cycle a requester SHALL receive at most one grant.
REQ-025 Responses SHALL have no backpressure; requesters SHALL accept every resp_valid pulse.
REQ-026 bram_en SHALL be 1 in any cycle with a grant or with a valid tag in stage 1 or 2, else 0.
REQ-027 Identical addresses on both ports in one cycle SHALL be legal; there are no writes.
REQ-028 On flush, all tag-pipeline valids SHALL clear on the next edge; no resp_valid SHALL pulse for lookups accepted before or during the flush cycle; rr_ptr SHALL be unchanged.
REQ-029 busy SHALL equal the OR of the stage-1 and stage-2 tag valids and the response-stage valid.
REQ-030 Throughput SHALL be two lookups per cycle, sustained, with no bubbles.

Reset
REQ-031 While rst is high: rr_ptr=0, all tag valids=0, resp_valid=0, resp_data=0, busy=0, bram_en=0, req_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight lookups, and no response for them SHALL appear after deassertion.

Structure
REQ-033 Package sbox_arb_pkg SHALL hold NREQ, ADDR_W, DATA_W, the BRAM latency constant (2) and the tag-record typedef.
REQ-034 Sub-module rr_pick2 SHALL implement the two-grant round-robin selection combinationally; the BRAM itself SHALL be instantiated outside this block.

Verification
REQ-035 Single request: req_valid=4'b0001, addr 0x000, accepted at T -> bram_addr_a=0x000, bram_addr_b=0, resp_valid[0] at T+3, resp_data[0]=0x00 (table entry 0).
REQ-036 All four requesting continuously from rr_ptr=0 -> grants {0,1}, {2,3}, {0,1} on successive cycles, rr_ptr wraps to 0, two resp pulses per cycle from T+3.
REQ-037 Requesters 1 and 3 at addr 0x001 together -> A=0x001, B=0x001, resp_data[1]=resp_data[3]=BRAM[0x001].
REQ-038 Flush one cycle after acceptance of requester 2 -> no resp_valid[2]; busy=0 two cycles later; bram_en drops to 0.
REQ-039 rst asserted at T+1 after acceptance, released at T+2 -> no resp_valid before T+6; all outputs 0 during reset.
REQ-040 Random traffic, 10,000 cycles -> every accepted lookup gets exactly one response at +3 cycles, matching a BRAM reference model; no requester starved beyond 2 cycles.
